// File: rtl/axi_bus_arbiter_if.sv
// Single-beat AXI4 master channel bundle for the fetch/data bus arbiter.
// The master modport is the arbiter side, the slave modport the memory side.
interface axi_bus_arbiter_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready,
      output awaddr, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  araddr, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready,
      input  awaddr, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_bus_arbiter.sv
// Shares one single-beat AXI master port between fetch and data access.
// Data wins ties unless fetch has been starved STARVE_LIMIT times.
module axi_bus_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_done,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_be,
   output logic        data_done,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   axi_bus_arbiter_if.master axi
);

   localparam int CW =
      (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_ADDR = 3'd1;
   localparam logic [2:0] RD_DATA = 3'd2;
   localparam logic [2:0] WR      = 3'd3;
   localparam logic [2:0] WR_RESP = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   logic [2:0]    state_q, state_d;
   logic          gnt_inst_q, gnt_inst_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;
   logic [CW-1:0] starve_cnt_q, starve_cnt_d;
   logic          aw_done_q, aw_done_d;
   logic          w_done_q, w_done_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic inst_win;
   logic aw_hit;
   logic w_hit;
   logic unused_resp;

   assign unused_resp = ^{axi.rresp[0], axi.bresp[0]};

   assign inst_win = inst_req &
      (~data_req | (starve_cnt_q >= LIM));
   assign aw_hit = aw_done_q | axi.awready;
   assign w_hit  = w_done_q | axi.wready;

   always_comb begin
      state_d      = state_q;
      gnt_inst_d   = gnt_inst_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      starve_cnt_d = starve_cnt_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      unique case (state_q)
         IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (inst_win) begin
               gnt_inst_d   = 1'b1;
               addr_d       = inst_addr;
               starve_cnt_d = '0;
               state_d      = RD_ADDR;
            end else if (data_req) begin
               gnt_inst_d = 1'b0;
               addr_d     = data_addr;
               wdata_d    = data_wdata;
               be_d       = data_be;
               // saturating count of fetches passed over
               if (!inst_req)
                  starve_cnt_d = '0;
               else if (starve_cnt_q >= LIM)
                  starve_cnt_d = LIM;
               else
                  starve_cnt_d = starve_cnt_q + CW'(1);
               state_d = data_we ? WR : RD_ADDR;
            end
         end
         RD_ADDR: begin
            if (axi.arready)
               state_d = RD_DATA;
         end
         RD_DATA: begin
            if (axi.rvalid) begin
               rdata_d = axi.rdata;
               err_d   = axi.rresp[1];
               state_d = DONE;
            end
         end
         WR: begin
            aw_done_d = aw_hit;
            w_done_d  = w_hit;
            if (aw_hit && w_hit)
               state_d = WR_RESP;
         end
         WR_RESP: begin
            if (axi.bvalid) begin
               err_d   = axi.bresp[1];
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         state_q      <= IDLE;
         gnt_inst_q   <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         starve_cnt_q <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_inst_q   <= gnt_inst_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         starve_cnt_q <= starve_cnt_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   assign axi.araddr  = addr_q;
   assign axi.arvalid = (state_q == RD_ADDR);
   assign axi.rready  = (state_q == RD_DATA);
   assign axi.awaddr  = addr_q;
   assign axi.awvalid = (state_q == WR) & ~aw_done_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = be_q;
   assign axi.wlast   = 1'b1;
   assign axi.wvalid  = (state_q == WR) & ~w_done_q;
   assign axi.bready  = (state_q == WR_RESP);

   assign inst_done  = (state_q == DONE) & gnt_inst_q;
   assign data_done  = (state_q == DONE) & ~gnt_inst_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
